// File: rtl/sram_access_seq_pkg.sv
// Shared types and default geometry for the SLC-3 SRAM access sequencer.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W  = 20;
    localparam int unsigned SRAM_DATA_W  = 16;
    localparam int unsigned SRAM_RD_WAIT = 2;
    localparam int unsigned SRAM_WR_WAIT = 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_RD_DONE  = 3'd2,
        S_WR_SETUP = 3'd3,
        S_WR_PULSE = 3'd4,
        S_WR_HOLD  = 3'd5
    } sram_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_access_seq_if.sv
// Request/done handshake plus off-chip SRAM pins, grouped for the sequencer.
interface sram_access_seq_if
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W
) ();

    logic              Req_Rd;
    logic              Req_Wr;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] Wr_Data;
    logic [DATA_W-1:0] Rd_Data;
    logic              Done;
    logic              Busy;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;
    logic              SRAM_WE_N;
    logic              SRAM_UB_N;
    logic              SRAM_LB_N;
    logic [DATA_W-1:0] DQ_Out;
    logic [DATA_W-1:0] DQ_In;
    logic              DQ_Drive;

    modport slave (
        input  Req_Rd, Req_Wr, Addr, Wr_Data, DQ_In,
        output Rd_Data, Done, Busy, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N,
               SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, DQ_Out, DQ_Drive
    );

    modport master (
        output Req_Rd, Req_Wr, Addr, Wr_Data, DQ_In,
        input  Rd_Data, Done, Busy, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N,
               SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, DQ_Out, DQ_Drive
    );

endinterface

// File: rtl/sram_access_seq_wait_cnt.sv
// Loadable down-counter that times the OE/WE strobe widths; saturates at zero.
module wait_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_access_seq.sv
// SRAM access sequencer: one read or write per request, Moore-decoded strobes, Done pulse.
module sram_access_seq
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W  = SRAM_ADDR_W,
    parameter int unsigned DATA_W  = SRAM_DATA_W,
    parameter int unsigned RD_WAIT = SRAM_RD_WAIT,
    parameter int unsigned WR_WAIT = SRAM_WR_WAIT
) (
    input logic              Clk,
    input logic              Reset,
    sram_access_seq_if.slave bus
);

    if (RD_WAIT < 1 || WR_WAIT < 1) begin : g_bad_wait
        $error("sram_access_seq: RD_WAIT and WR_WAIT must both be >= 1");
    end

    localparam int unsigned CNT_W = $clog2(max_u(RD_WAIT, WR_WAIT) + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    sram_state_t       state_q;
    sram_state_t       state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dq_out_q;
    logic [DATA_W-1:0] rd_data_q;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    logic ce_n, oe_n, we_n, drive, done, busy;

    wait_cnt #(.W(CNT_W)) u_wait_cnt (
        .Clk        (Clk),
        .Reset      (Reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Read wins when both requests are high; the write is simply not accepted.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Req_Rd) begin
                    state_d      = S_RD_WAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = RD_LOAD;
                end else if (bus.Req_Wr) begin
                    state_d = S_WR_SETUP;
                end
            end
            S_RD_WAIT: begin
                if (cnt_zero) state_d = S_RD_DONE;
                else          cnt_dec = 1'b1;
            end
            S_RD_DONE: state_d = S_IDLE;
            S_WR_SETUP: begin
                state_d      = S_WR_PULSE;
                cnt_load     = 1'b1;
                cnt_load_val = WR_LOAD;
            end
            S_WR_PULSE: begin
                if (cnt_zero) state_d = S_WR_HOLD;
                else          cnt_dec = 1'b1;
            end
            S_WR_HOLD: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ce_n  = 1'b1;
        oe_n  = 1'b1;
        we_n  = 1'b1;
        drive = 1'b0;
        done  = 1'b0;
        busy  = (state_q != S_IDLE);
        case (state_q)
            S_RD_WAIT:  begin ce_n = 1'b0; oe_n = 1'b0; end
            S_RD_DONE:  begin ce_n = 1'b0; done = 1'b1; end
            S_WR_SETUP: begin ce_n = 1'b0; drive = 1'b1; end
            S_WR_PULSE: begin ce_n = 1'b0; drive = 1'b1; we_n = 1'b0; end
            S_WR_HOLD:  begin ce_n = 1'b0; drive = 1'b1; done = 1'b1; end
            default:    ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            dq_out_q  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && (bus.Req_Rd || bus.Req_Wr)) begin
                addr_q <= bus.Addr;
            end
            if (state_q == S_IDLE && bus.Req_Wr && !bus.Req_Rd) begin
                dq_out_q <= bus.Wr_Data;
            end
            if (state_q == S_RD_WAIT && cnt_zero) begin
                rd_data_q <= bus.DQ_In;
            end
        end
    end

    assign bus.Rd_Data   = rd_data_q;
    assign bus.Done      = done;
    assign bus.Busy      = busy;
    assign bus.SRAM_ADDR = addr_q;
    assign bus.SRAM_CE_N = ce_n;
    assign bus.SRAM_OE_N = oe_n;
    assign bus.SRAM_WE_N = we_n;
    assign bus.SRAM_UB_N = 1'b0;
    assign bus.SRAM_LB_N = 1'b0;
    assign bus.DQ_Out    = dq_out_q;
    assign bus.DQ_Drive  = drive;

endmodule

// File: doc/sram_access_seq.md
# sram_access_seq

SRAM access sequencer between the SLC-3 control unit and the off-chip 16-bit asynchronous SRAM. It replaces fixed wait-state control states with a request/done handshake. It generates glitch-free CE/OE/WE strobes, counts parameterised wait states, drives the split data bus and captures read data into a holding register. The control unit issues one read or write at a time and advances its FSM on `Done`.

## Interface
- `ADDR_W`, 20, SRAM address width.
- `DATA_W`, 16, data word width.
- `RD_WAIT`, 2, cycles OE_N held low before capture; must be ≥1, otherwise elaboration fails.
- `WR_WAIT`, 2, cycles WE_N held low; must be ≥1, otherwise elaboration fails.
- `Clk`  in  1  clock.
- `Reset`  in  1  reset Reset, synchronous, active-high; clock Clk.
- `Req_Rd`  in  1  read request, level.
- `Req_Wr`  in  1  write request, level.
- `Addr`  in  ADDR_W  access address, sampled at accept.
- `Wr_Data`  in  DATA_W  write data, sampled at accept.
- `Rd_Data`  out  DATA_W  last captured read word.
- `Done`  out  1  one-cycle completion pulse.
- `Busy`  out  1  high whenever state ≠ IDLE.
- `SRAM_ADDR`  out  ADDR_W  registered address.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  active-low strobes.
- `DQ_Out`  out  DATA_W  registered write data.
- `DQ_In`  in  DATA_W  SRAM data in; the tristate buffer lives at top level.
- `DQ_Drive`  out  1  enables the top-level DQ tristate.

## Operation
- States: IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE, Req_Rd=1: latch Addr into SRAM_ADDR, load wait counter with RD_WAIT-1, go to RD_WAIT.
- IDLE, Req_Wr=1 and Req_Rd=0: latch Addr and Wr_Data into DQ_Out, go to WR_SETUP.
- Both requests high: the read is served. The write is not queued; the requester re-issues it.
- RD_WAIT: CE_N=0, OE_N=0. When counter==0: `Rd_Data<=DQ_In` on that edge, go to RD_DONE. Otherwise decrement.
- RD_DONE: Done=1, CE_N=0, OE_N=1, go to IDLE.
- WR_SETUP: CE_N=0, DQ_Drive=1, WE_N=1. Load counter with WR_WAIT-1, go to WR_PULSE.
- WR_PULSE: CE_N=0, DQ_Drive=1, WE_N=0. When counter==0, go to WR_HOLD; otherwise decrement.
- WR_HOLD: CE_N=0, DQ_Drive=1, WE_N=1, Done=1, go to IDLE.
- Strobes, DQ_Drive, Done and Busy are Moore-decoded from the state register only, with no input paths.
- UB_N and LB_N are tied 0 (word access only).
- OE_N and WE_N are never low in the same cycle. DQ_Drive is never 1 while OE_N=0.
- Rd_Data changes only on read capture or reset.

## Timing
- Reset values:
  - state IDLE.
  - CE_N=OE_N=WE_N=1.
  - DQ_Drive=0, Done=0, Busy=0.
  - Rd_Data=0, SRAM_ADDR=0, DQ_Out=0.
- Read: accepted at edge 0. OE_N is low for cycles 1..RD_WAIT. Capture happens at edge RD_WAIT. Done is high in cycle RD_WAIT+1. Total RD_WAIT+1 cycles busy.
- Write: accepted at edge 0. WR_SETUP is cycle 1. WE_N is low for cycles 2..WR_WAIT+1. Done is high in cycle WR_WAIT+2.
- Address and data stay stable for the whole access, including the setup and hold cycles.
- Handshake: the requester holds Req until it sees Done and must drop it in the cycle after Done. A request still high in IDLE starts a new access, so back-to-back accesses have no dead cycle.
- Requests and Addr are ignored while Busy.
- Reset mid-access: at the next edge the state goes to IDLE, all strobes go inactive, DQ_Drive=0 and Rd_Data=0. No Done is generated.

## Structure
- Package `sram_pkg` holds:
  - the state enum `sram_state_t`;
  - default constants `SRAM_ADDR_W`, `SRAM_DATA_W`, `SRAM_RD_WAIT`, `SRAM_WR_WAIT`.
- Sub-module `wait_cnt`: loadable down-counter with `$clog2(max(RD_WAIT,WR_WAIT)+1)` bits and a `zero` flag, instanced once.
- Output decode and next-state logic stay in `sram_access_seq`.

## Test plan
- Reset, idle: all outputs at their reset values; CE_N=OE_N=WE_N=1 for 10 cycles with no requests.
- Read: Addr=0x00012, DQ_In=0xBEEF, Req_Rd held.
  - OE_N is low for exactly 2 cycles.
  - Done pulses in cycle 3.
  - Rd_Data=0xBEEF.
  - SRAM_ADDR=0x00012 throughout.
- Write: Addr=0x00034, Wr_Data=0x1234, Req_Wr held.
  - DQ_Drive is 1 for cycles 1-4.
  - WE_N is low in cycles 2-3 only.
  - Done is in cycle 4.
  - DQ_Out=0x1234.
- Both requests asserted together: a read is performed (OE_N pulses, WE_N stays 1); no write occurs.
- Back-to-back reads: Req_Rd held across two Done pulses with Addr 0x1 then 0x2. The second access starts in the cycle after the first Done, and Rd_Data updates on each access.
- Reset asserted in WR_PULSE: WE_N=1 and DQ_Drive=0 from the next cycle. Done is never pulsed and Busy=0.
